axi_slave_write_if: RTL and testbench

AXI4 write-channel responder sitting behind the interconnect's AW/W/B path, in front of a simple SRAM-style memory or register bank. Accepts one write burst at a time on AW, generates per-beat addresses for FIXED/INCR/WRAP bursts, and forwards each accepted W beat as a single-cycle write strobe on the memory port. Returns one B response carrying the captured ID. It is the terminating end of the write-address path that the master-side AW mux drives.

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_burst_addr_gen.sv | 38 +++
 rtl/axi_slave_write_if.sv | 151 +++++++++++++++
 tb/tb_axi_slave_write_if.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI write/read responder types.
// Burst encodings, response codes and responder FSM states.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } wr_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for FIXED/INCR/WRAP bursts.
// Pure combinational; wraps modulo 2^ADDR_W.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int SIZE_W = 3
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [SIZE_W-1:0] size,
    input  burst_e            burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] blk;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] incr;

    // WRAP keeps the block-aligned upper bits and rolls the offset
    always_comb begin
        step      = ADDR_W'(1) << size;
        blk       = (ADDR_W'(len) + ADDR_W'(1)) << size;
        mask      = blk - ADDR_W'(1);
        incr      = addr + step;
        next_addr = addr;
        unique case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr;
            BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
            BURST_RSVD:  next_addr = addr;
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_write_if.sv
// AXI4 write responder: AW capture, per-beat memory strobes, one B.
// One burst in flight; handshake readies/valids are registered.
module axi_slave_write_if
    import axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int SIZE_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_W-1:0]     s_AWID,
    input  logic [ADDR_W-1:0]   s_AWADDR,
    input  logic [LEN_W-1:0]    s_AWLEN,
    input  logic [SIZE_W-1:0]   s_AWSIZE,
    input  logic [1:0]          s_AWBURST,
    input  logic                s_AWVALID,
    output logic                s_AWREADY,
    input  logic [DATA_W-1:0]   s_WDATA,
    input  logic [DATA_W/8-1:0] s_WSTRB,
    input  logic                s_WLAST,
    input  logic                s_WVALID,
    output logic                s_WREADY,
    output logic [ID_W-1:0]     s_BID,
    output logic [1:0]          s_BRESP,
    output logic                s_BVALID,
    input  logic                s_BREADY,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_err
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int MAX_SIZE = $clog2(STRB_W);

    wr_state_e         state;
    wr_state_e         state_n;
    logic              err_q;
    logic              err_n;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_nx;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [SIZE_W-1:0] size_q;
    burst_e            burst_q;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              last_cnt;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .SIZE_W (SIZE_W)
    ) u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (addr_nx)
    );

    assign aw_hs     = s_AWVALID && s_AWREADY;
    assign w_hs      = s_WVALID && s_WREADY;
    assign b_hs      = s_BVALID && s_BREADY;
    assign last_cnt  = (cnt_q == len_q);
    assign mem_we    = w_hs && (burst_q != BURST_RSVD);
    assign mem_addr  = addr_q;
    assign mem_wdata = s_WDATA;
    assign mem_wstrb = s_WSTRB;

    // Next state and sticky error flag
    always_comb begin
        state_n = state;
        err_n   = err_q;
        unique case (state)
            ST_IDLE: begin
                if (aw_hs) begin
                    state_n = ST_DATA;
                    err_n   = (s_AWSIZE > SIZE_W'(MAX_SIZE))
                           || (s_AWBURST == BURST_RSVD);
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (last_cnt != s_WLAST) err_n = 1'b1;
                    if (mem_we && mem_err)   err_n = 1'b1;
                    if (last_cnt || s_WLAST) state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_hs) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            err_q     <= 1'b0;
            s_AWREADY <= 1'b0;
            s_WREADY  <= 1'b0;
            s_BVALID  <= 1'b0;
        end else begin
            state     <= state_n;
            err_q     <= err_n;
            s_AWREADY <= (state_n == ST_IDLE);
            s_WREADY  <= (state_n == ST_DATA);
            s_BVALID  <= (state_n == ST_RESP);
        end
    end

    // Burst context capture, beat stepping and B payload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            s_BID   <= '0;
            s_BRESP <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                id_q    <= s_AWID;
                addr_q  <= s_AWADDR;
                len_q   <= s_AWLEN;
                size_q  <= s_AWSIZE;
                burst_q <= burst_e'(s_AWBURST);
                cnt_q   <= '0;
            end
            if (w_hs) begin
                addr_q <= addr_nx;
                cnt_q  <= cnt_q + LEN_W'(1);
            end
            if (state == ST_DATA && state_n == ST_RESP) begin
                s_BID   <= id_q;
                s_BRESP <= err_n ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_write_if.sv
// Directed + randomized bench for axi_slave_write_if.
// Beat addresses and responses come from a closed-form burst model.
module tb_axi_slave_write_if;

    logic        clk;
    logic        rst_n;
    logic [3:0]  s_AWID;
    logic [31:0] s_AWADDR;
    logic [7:0]  s_AWLEN;
    logic [2:0]  s_AWSIZE;
    logic [1:0]  s_AWBURST;
    logic        s_AWVALID;
    logic        s_AWREADY;
    logic [31:0] s_WDATA;
    logic [3:0]  s_WSTRB;
    logic        s_WLAST;
    logic        s_WVALID;
    logic        s_WREADY;
    logic [3:0]  s_BID;
    logic [1:0]  s_BRESP;
    logic        s_BVALID;
    logic        s_BREADY;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    axi_slave_write_if #(
        .ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(8), .SIZE_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_AWID(s_AWID), .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN),
        .s_AWSIZE(s_AWSIZE), .s_AWBURST(s_AWBURST),
        .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
        .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WLAST(s_WLAST),
        .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
        .s_BID(s_BID), .s_BRESP(s_BRESP), .s_BVALID(s_BVALID),
        .s_BREADY(s_BREADY),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Address of beat i computed directly from the burst definition
    function automatic logic [31:0] model_addr(input logic [31:0] a,
        input int len, input int size, input int burst, input int i);
        longint step, blk, base, off, start;
        start = longint'(a);
        step  = longint'(1) << size;
        blk   = longint'(len + 1) * step;
        case (burst)
            1: return 32'(start + longint'(i) * step);
            2: begin
                base = (start / blk) * blk;
                off  = (start - base + longint'(i) * step) % blk;
                return 32'(base + off);
            end
            default: return a;
        endcase
    endfunction

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
        input int len, input int size, input int burst, input int wlast_at,
        input int err_at, input int gmin, input int gmax, input int bdelay);
        int nb, waited, g;
        bit wr, exp_err;
        logic [31:0] d;
        logic [3:0] st;
        nb = ((wlast_at < len) ? wlast_at : len) + 1;
        wr = (burst != 3);
        exp_err = (burst == 3) || (size > 2) || (wlast_at != len)
               || (wr && err_at >= 0 && err_at < nb);
        waited = 0;
        while (s_AWREADY !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (s_AWREADY !== 1'b1) begin
            check("aw_wait_timeout", s_AWREADY, 1);
            return;
        end
        s_AWID = id; s_AWADDR = addr; s_AWLEN = 8'(len);
        s_AWSIZE = 3'(size); s_AWBURST = 2'(burst); s_AWVALID = 1'b1;
        @(posedge clk); #1;
        s_AWVALID = 1'b0;
        check("aw_to_wready", s_WREADY, 1);
        check("aw_busy", s_AWREADY, 0);
        for (int i = 0; i < nb; i++) begin
            g = $urandom_range(gmax, gmin);
            repeat (g) begin
                s_WVALID = 1'b0; #1;
                check("gap_we", mem_we, 0);
                @(posedge clk); #1;
                check("gap_wready", s_WREADY, 1);
            end
            d = $urandom; st = 4'($urandom);
            s_WDATA = d; s_WSTRB = st; s_WVALID = 1'b1;
            s_WLAST = (i == wlast_at); mem_err = (i == err_at);
            #1;
            check("beat_we", mem_we, wr);
            if (wr) begin
                check("beat_addr", mem_addr, model_addr(addr, len, size, burst, i));
                check("beat_wdata", mem_wdata, d);
                check("beat_wstrb", mem_wstrb, st);
            end
            @(posedge clk); #1;
            s_WVALID = 1'b0; s_WLAST = 1'b0; mem_err = 1'b0;
        end
        check("end_wready", s_WREADY, 0);
        check("bvalid", s_BVALID, 1);
        check("bid", s_BID, id);
        check("bresp", s_BRESP, exp_err ? 2'b10 : 2'b00);
        repeat (bdelay) begin
            @(posedge clk); #1;
            check("bhold_valid", s_BVALID, 1);
            check("bhold_id", s_BID, id);
            check("bhold_resp", s_BRESP, exp_err ? 2'b10 : 2'b00);
            check("bhold_awready", s_AWREADY, 0);
        end
        s_BREADY = 1'b1;
        @(posedge clk); #1;
        s_BREADY = 1'b0;
        check("b_done", s_BVALID, 0);
        check("aw_back", s_AWREADY, 1);
    endtask

    initial begin
        int len, size, burst, wl, ea;
        rst_n = 1'b0; s_AWVALID = 1'b0; s_AWID = '0; s_AWADDR = '0;
        s_AWLEN = '0; s_AWSIZE = '0; s_AWBURST = '0;
        s_WDATA = '0; s_WSTRB = '0; s_WLAST = 1'b0; s_WVALID = 1'b0;
        s_BREADY = 1'b0; mem_err = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", s_AWREADY, 0);
        check("rst_wready", s_WREADY, 0);
        check("rst_bvalid", s_BVALID, 0);
        check("rst_bid", s_BID, 0);
        check("rst_bresp", s_BRESP, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_awready", s_AWREADY, 1);

        run_burst(4'h5, 32'h100, 3, 2, 1, 3, -1, 0, 0, 0);
        run_burst(4'ha, 32'h38, 3, 2, 2, 3, -1, 0, 0, 0);
        run_burst(4'h3, 32'h20, 2, 2, 0, 2, -1, 1, 2, 5);
        run_burst(4'h7, 32'h200, 3, 2, 1, 1, -1, 0, 0, 1);
        run_burst(4'hc, 32'h300, 0, 2, 3, 0, -1, 0, 0, 0);
        run_burst(4'h9, 32'h400, 3, 2, 1, 3, 2, 0, 0, 0);
        run_burst(4'h1, 32'hffff_fffc, 1, 2, 1, 1, -1, 0, 0, 0);

        // Reset during beat 1 of an INCR burst
        s_AWID = 4'h6; s_AWADDR = 32'h500; s_AWLEN = 8'd3;
        s_AWSIZE = 3'd2; s_AWBURST = 2'b01; s_AWVALID = 1'b1;
        @(posedge clk); #1;
        s_AWVALID = 1'b0;
        s_WVALID = 1'b1; s_WDATA = 32'h1111_1111; s_WSTRB = 4'hf;
        @(posedge clk); #1;
        s_WDATA = 32'h2222_2222; rst_n = 1'b0;
        @(posedge clk); #1;
        s_WVALID = 1'b0; s_WDATA = '0; s_WSTRB = '0;
        check("mid_rst_awready", s_AWREADY, 0);
        check("mid_rst_wready", s_WREADY, 0);
        check("mid_rst_bvalid", s_BVALID, 0);
        check("mid_rst_bid", s_BID, 0);
        check("mid_rst_bresp", s_BRESP, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_awready", s_AWREADY, 1);
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_no_b", s_BVALID, 0);
        end

        for (int k = 0; k < 24; k++) begin
            burst = $urandom_range(3, 0);
            if (burst == 2) len = (1 << $urandom_range(4, 1)) - 1;
            else len = $urandom_range(7, 0);
            size = ($urandom_range(9, 0) == 0) ? 3 : $urandom_range(2, 0);
            wl = ($urandom_range(5, 0) == 0) ? $urandom_range(len + 1, 0) : len;
            ea = ($urandom_range(4, 0) == 0) ? $urandom_range(len, 0) : -1;
            run_burst(4'($urandom), $urandom, len, size, burst, wl, ea,
                      0, $urandom_range(2, 0), $urandom_range(3, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
